// File: rtl/dt_stats_scan.sv
// Sweeps the distance-transform result RAM after the engine finishes and reports
// max distance, its first address, object-pixel count and distance sum. Optional threshold counter: DT_STATS_THR_EN.
module dt_stats_scan #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     res_rd,
  output logic [ADDR_W-1:0]        res_addr,
  input  logic [DATA_W-1:0]        res_di,
  output logic [DATA_W-1:0]        max_val,
  output logic [ADDR_W-1:0]        max_addr,
  output logic [ADDR_W:0]          obj_cnt,
  output logic [ADDR_W+DATA_W-1:0] dist_sum
`ifdef DT_STATS_THR_EN
  ,
  input  logic [DATA_W-1:0]        thr,
  output logic [ADDR_W:0]          thr_cnt
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic [CNT_W-1:0]  obj_cnt_q, obj_cnt_d;
  logic [SUM_W-1:0]  dist_sum_q, dist_sum_d;
`ifdef DT_STATS_THR_EN
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]  thr_cnt_q, thr_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    vld_d      = (state_q == READ);
    daddr_d    = addr_q;
    max_val_d  = max_val_q;
    max_addr_d = max_addr_q;
    obj_cnt_d  = obj_cnt_q;
    dist_sum_d = dist_sum_q;
`ifdef DT_STATS_THR_EN
    thr_d      = thr_q;
    thr_cnt_d  = thr_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = READ;
          addr_d     = '0;
          max_val_d  = '0;
          max_addr_d = '0;
          obj_cnt_d  = '0;
          dist_sum_d = '0;
`ifdef DT_STATS_THR_EN
          thr_d      = thr;
          thr_cnt_d  = '0;
`endif
        end
      end
      READ: begin
        // Counter wraps to zero after the last address, so res_addr idles at 0.
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // vld_q is never set in IDLE, so this cannot collide with the start-time clear.
    if (vld_q) begin
      dist_sum_d = dist_sum_q + SUM_W'(res_di);
      obj_cnt_d  = obj_cnt_q + CNT_W'(res_di != '0);
      if (res_di > max_val_q) begin
        max_val_d  = res_di;
        max_addr_d = daddr_q;
      end
`ifdef DT_STATS_THR_EN
      thr_cnt_d = thr_cnt_q + CNT_W'(res_di >= thr_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      vld_q      <= 1'b0;
      daddr_q    <= '0;
      max_val_q  <= '0;
      max_addr_q <= '0;
      obj_cnt_q  <= '0;
      dist_sum_q <= '0;
`ifdef DT_STATS_THR_EN
      thr_q      <= '0;
      thr_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
      daddr_q    <= daddr_d;
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
      obj_cnt_q  <= obj_cnt_d;
      dist_sum_q <= dist_sum_d;
`ifdef DT_STATS_THR_EN
      thr_q      <= thr_d;
      thr_cnt_q  <= thr_cnt_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign res_rd   = (state_q == READ);
  assign res_addr = addr_q;
  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;
  assign obj_cnt  = obj_cnt_q;
  assign dist_sum = dist_sum_q;
`ifdef DT_STATS_THR_EN
  assign thr_cnt  = thr_cnt_q;
`endif

endmodule

// File: tb/tb_dt_stats_scan.sv
// Directed bench for dt_stats_scan: RAM model with one-cycle read latency and
// hand-computed statistics for a handful of distance maps.
module tb_dt_stats_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic [7:0]  max_val;
  logic [13:0] max_addr;
  logic [14:0] obj_cnt;
  logic [21:0] dist_sum;
`ifdef DT_STATS_THR_EN
  logic [7:0]  thr;
  logic [14:0] thr_cnt;
`endif

  logic [7:0] mem [16384];
  int n_cmp = 0;
  int n_err = 0;
  int dcyc;
  int gaps;

  dt_stats_scan #(.ADDR_W(14), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .max_val  (max_val),
    .max_addr (max_addr),
    .obj_cnt  (obj_cnt),
    .dist_sum (dist_sum)
`ifdef DT_STATS_THR_EN
    ,
    .thr      (thr),
    .thr_cnt  (thr_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16384; i++) mem[i] = v;
  endtask

  task automatic check_stats(input string pfx, input int mv, input int ma, input int oc, input int ds);
    check({pfx, "_max_val"},  32'(max_val),  mv);
    check({pfx, "_max_addr"}, 32'(max_addr), ma);
    check({pfx, "_obj_cnt"},  32'(obj_cnt),  oc);
    check({pfx, "_dist_sum"}, 32'(dist_sum), ds);
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_busy"},     32'(busy),     0);
    check({pfx, "_done"},     32'(done),     0);
    check({pfx, "_res_rd"},   32'(res_rd),   0);
    check({pfx, "_res_addr"}, 32'(res_addr), 0);
    check_stats(pfx, 0, 0, 0, 0);
  endtask

  // Entered at a falling edge with the DUT idle; cycle 1 is the period after the accepting edge.
  // Returns in the DONE cycle, or one cycle after a mid-scan reset.
  task automatic run_scan(input int extra_start_at, input int reset_at,
                          output int done_cyc, output int gap_cnt);
    done_cyc = 0;
    gap_cnt  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 16400; c++) begin
      if (c <= 16384 && (res_rd !== 1'b1 || res_addr !== 14'(c - 1))) gap_cnt++;
      if (c == 1) check("scan_busy_c1", 32'(busy), 1);
      if (done === 1'b1 && done_cyc == 0) done_cyc = c;
      start = (c == extra_start_at);
`ifdef DT_STATS_THR_EN
      if (c == 5000) thr = 8'd0;
`endif
      if (c == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (done_cyc != 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
`ifdef DT_STATS_THR_EN
    thr = 8'd0;
`endif
    fill(8'd0);
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // All-zero map
    run_scan(0, 0, dcyc, gaps);
    check("zero_done_cyc", dcyc, 16386);
    check("zero_addr_seq", gaps, 0);
    check("zero_busy_in_done", 32'(busy), 1);
    check_stats("zero", 0, 0, 0, 0);
    @(negedge clk);
    check("zero_idle_busy", 32'(busy), 0);
    check("zero_idle_done", 32'(done), 0);

    // Single object pixel
    fill(8'd0);
    mem[8321] = 8'd5;
    run_scan(0, 0, dcyc, gaps);
    check("single_done_cyc", dcyc, 16386);
    check_stats("single", 5, 8321, 1, 5);
    @(negedge clk);

    // All 255, with a second start at cycle 500 that must be ignored
    fill(8'd255);
    run_scan(500, 0, dcyc, gaps);
    check("full_done_cyc", dcyc, 16386);
    check("full_addr_seq", gaps, 0);
    check_stats("full", 255, 0, 16384, 4177920);
    repeat (4) @(negedge clk);
    check("full_no_requeue_busy", 32'(busy), 0);
    check("full_no_requeue_rd", 32'(res_rd), 0);
    check_stats("full_held", 255, 0, 16384, 4177920);

    // Reset in the middle of a scan
    run_scan(0, 9000, dcyc, gaps);
    check_idle_zero("midreset");
    @(negedge clk);

    // Tie on max value keeps the earlier address
    fill(8'd0);
    mem[100] = 8'd7;
    mem[200] = 8'd7;
    run_scan(0, 0, dcyc, gaps);
    check("tie_done_cyc", dcyc, 16386);
    check("tie_addr_seq", gaps, 0);
    check_stats("tie", 7, 100, 2, 14);
    @(negedge clk);

`ifdef DT_STATS_THR_EN
    // Threshold sampled at start; the mid-scan change to 0 must not count zero pixels
    fill(8'd0);
    mem[10] = 8'd2;
    mem[20] = 8'd3;
    mem[30] = 8'd4;
    thr = 8'd3;
    run_scan(0, 0, dcyc, gaps);
    check("thr_done_cyc", dcyc, 16386);
    check("thr_cnt", 32'(thr_cnt), 2);
    check_stats("thr", 4, 30, 3, 9);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
